// File: rtl/sap_obi_timeout_guard.sv
// sap_obi_timeout_guard
// Response-phase watchdog on the OBI path between the SAP cluster external
// slave port and the SoC interconnect. One transaction is forwarded at a time.
// If the downstream target never answers, a single error response carrying
// ERR_RDATA is returned to the cluster. After that, the guard waits (bounded)
// for a late response and discards it before accepting new traffic.
//
// Optional feature macro: SAP_OBI_TIMEOUT_IRQ_EN
//   When defined, this adds a sticky timeout interrupt (timeout_irq_o), its
//   clear input (irq_clr_i) and a saturating timeout counter (timeout_cnt_o).
//   When undefined, those ports and their logic are absent.

module sap_obi_timeout_guard #(
   parameter int unsigned TIMEOUT   = 32'd1024,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // cluster side
   input  logic        s_req_i,
   output logic        s_gnt_o,
   input  logic [31:0] s_addr_i,
   input  logic        s_we_i,
   input  logic [3:0]  s_be_i,
   input  logic [31:0] s_wdata_i,
   output logic        s_rvalid_o,
   output logic [31:0] s_rdata_o,
   output logic        s_err_o,
   // interconnect side
   output logic        m_req_o,
   input  logic        m_gnt_i,
   output logic [31:0] m_addr_o,
   output logic        m_we_o,
   output logic [3:0]  m_be_o,
   output logic [31:0] m_wdata_o,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
   ,
   input  logic        irq_clr_i,
   output logic        timeout_irq_o,
   output logic [7:0]  timeout_cnt_o
`endif
);

   // Counter is wide enough to hold TIMEOUT itself (its saturation value).
   localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_R  = 2'd1,
      ERR_RSP = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_nxt_s;
   logic            cnt_last_s;

   // Saturating increment of the watchdog counter.
   function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      if (v >= CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   assign cnt_last_s = (cnt_r == CNT_LAST);

   // Request attributes are forwarded unchanged; m_req_o qualifies them.
   assign m_addr_o  = s_addr_i;
   assign m_we_o    = s_we_i;
   assign m_be_o    = s_be_i;
   assign m_wdata_o = s_wdata_i;

   // Next-state decision. A real rvalid in the last waiting cycle takes
   // precedence over the timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (s_req_i && m_gnt_i) begin
               state_nxt_s = WAIT_R;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_R: begin
            if (m_rvalid_i) begin
               state_nxt_s = IDLE;
            end else if (cnt_last_s) begin
               state_nxt_s = ERR_RSP;
            end else begin
               state_nxt_s = WAIT_R;
            end
         end
         ERR_RSP: begin
            state_nxt_s = DRAIN;
         end
         DRAIN: begin
            if (m_rvalid_i || cnt_last_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Counter restarts from zero on every state change and only runs while
   // waiting for a response (WAIT_R or DRAIN).
   always_comb begin
      cnt_nxt_s = CNT_ZERO;
      if (state_nxt_s != state_r) begin
         cnt_nxt_s = CNT_ZERO;
      end else if ((state_r == WAIT_R) || (state_r == DRAIN)) begin
         cnt_nxt_s = cnt_sat_inc(cnt_r);
      end else begin
         cnt_nxt_s = CNT_ZERO;
      end
   end

   // FSM state and watchdog counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Handshake and response steering. These are combinational so that
   // forwarding adds no latency; everything not stated for a state stays 0.
   always_comb begin
      s_gnt_o    = 1'b0;
      m_req_o    = 1'b0;
      s_rvalid_o = 1'b0;
      s_rdata_o  = 32'h0000_0000;
      s_err_o    = 1'b0;
      case (state_r)
         IDLE: begin
            m_req_o = s_req_i;
            s_gnt_o = m_gnt_i;
         end
         WAIT_R: begin
            s_rvalid_o = m_rvalid_i;
            s_rdata_o  = m_rdata_i;
         end
         ERR_RSP: begin
            s_rvalid_o = 1'b1;
            s_rdata_o  = ERR_RDATA;
            s_err_o    = 1'b1;
         end
         DRAIN: begin
            s_rvalid_o = 1'b0;
         end
         default: begin
            s_rvalid_o = 1'b0;
         end
      endcase
   end

`ifdef SAP_OBI_TIMEOUT_IRQ_EN
   logic       timeout_evt_s;
   logic       irq_r;
   logic [7:0] tcnt_r;

   // Saturating increment for the 8-bit timeout counter.
   function automatic logic [7:0] tcnt_sat_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   assign timeout_evt_s = (state_r == ERR_RSP);

   // Sticky interrupt plus timeout count. A timeout in the same cycle as a
   // clear wins, so the count restarts at one instead of zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_r  <= 1'b0;
         tcnt_r <= 8'd0;
      end else begin
         if (timeout_evt_s) begin
            irq_r <= 1'b1;
         end else if (irq_clr_i) begin
            irq_r <= 1'b0;
         end else begin
            irq_r <= irq_r;
         end

         if (irq_clr_i && timeout_evt_s) begin
            tcnt_r <= 8'd1;
         end else if (irq_clr_i) begin
            tcnt_r <= 8'd0;
         end else if (timeout_evt_s) begin
            tcnt_r <= tcnt_sat_inc(tcnt_r);
         end else begin
            tcnt_r <= tcnt_r;
         end
      end
   end

   assign timeout_irq_o = irq_r;
   assign timeout_cnt_o = tcnt_r;
`endif

endmodule

// File: tb/tb_sap_obi_timeout_guard.sv
// Self-checking bench for sap_obi_timeout_guard (TIMEOUT = 16).
// Expected responses are queued when a transaction is granted. A negedge
// monitor then pops and compares each response that the DUT presents.
// Compile with SAP_OBI_TIMEOUT_IRQ_EN defined to also exercise the IRQ ports.

module tb_sap_obi_timeout_guard;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        s_req;
   logic        s_gnt;
   logic [31:0] s_addr;
   logic        s_we;
   logic [3:0]  s_be;
   logic [31:0] s_wdata;
   logic        s_rvalid;
   logic [31:0] s_rdata;
   logic        s_err;
   logic        m_req;
   logic        m_gnt;
   logic [31:0] m_addr;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        m_rvalid;
   logic [31:0] m_rdata;
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
   logic        irq_clr;
   logic        timeout_irq;
   logic [7:0]  timeout_cnt;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } rsp_t;

   rsp_t sb[$];
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;
   int   g;

   sap_obi_timeout_guard #(.TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .s_req_i    (s_req),
      .s_gnt_o    (s_gnt),
      .s_addr_i   (s_addr),
      .s_we_i     (s_we),
      .s_be_i     (s_be),
      .s_wdata_i  (s_wdata),
      .s_rvalid_o (s_rvalid),
      .s_rdata_o  (s_rdata),
      .s_err_o    (s_err),
      .m_req_o    (m_req),
      .m_gnt_i    (m_gnt),
      .m_addr_o   (m_addr),
      .m_we_o     (m_we),
      .m_be_o     (m_be),
      .m_wdata_o  (m_wdata),
      .m_rvalid_i (m_rvalid),
      .m_rdata_i  (m_rdata)
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      ,
      .irq_clr_i     (irq_clr),
      .timeout_irq_o (timeout_irq),
      .timeout_cnt_o (timeout_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented response against the queue head and
   // flag expected responses whose cycle has passed without appearing.
   always @(negedge clk) begin
      rsp_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         check("missing_rvalid", 32'(cyc), 32'(e.cyc));
      end
      if (s_rvalid) begin
         if (sb.size() == 0) begin
            check("unexpected_rvalid", 32'(s_rvalid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            check("rsp_rdata", s_rdata, e.data);
            check("rsp_err", 32'(s_err), 32'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b1; s_req = 1'b0; s_addr = 32'h0; s_we = 1'b0; s_be = 4'h0;
      s_wdata = 32'h0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      irq_clr = 1'b0;
`endif
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_gnt", 32'(s_gnt), 32'd0);
      check("reset_rvalid", 32'(s_rvalid), 32'd0);
      check("reset_err", 32'(s_err), 32'd0);
      check("reset_mreq", 32'(m_req), 32'd0);
      check("reset_rdata", s_rdata, 32'h0);
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      check("reset_irq", 32'(timeout_irq), 32'd0);
      check("reset_tcnt", 32'(timeout_cnt), 32'd0);
`endif
      step(); rst_ni = 1'b1;
      step();

      // Normal read: response 3 cycles after the grant.
      s_req = 1'b1; s_addr = 32'h2000_0000; s_we = 1'b0; s_be = 4'hF; m_gnt = 1'b1;
      g = cyc; sb.push_back('{32'h1234_5678, 1'b0, g + 3});
      @(negedge clk);
      check("fwd_mreq", 32'(m_req), 32'd1);
      check("fwd_gnt", 32'(s_gnt), 32'd1);
      check("fwd_addr", m_addr, 32'h2000_0000);
      check("fwd_be", 32'(m_be), 32'hF);
      step(); s_req = 1'b0; m_gnt = 1'b0;
      step();
      step(); m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;

      // Timeout write, then a late response 5 cycles after the error.
      step(); s_req = 1'b1; s_we = 1'b1; s_addr = 32'h3000_0010; s_wdata = 32'h0BAD_F00D; m_gnt = 1'b1;
      g = cyc; sb.push_back('{32'hDEAD_BEEF, 1'b1, g + 17});
      @(negedge clk);
      check("fwd_wdata", m_wdata, 32'h0BAD_F00D);
      check("fwd_we", 32'(m_we), 32'd1);
      step(); s_req = 1'b0; m_gnt = 1'b0;
      repeat (16) step();               // now cycle g+17 (error cycle)
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      @(negedge clk);
      check("irq_before", 32'(timeout_irq), 32'd0);
`endif
      step(); s_req = 1'b1; s_addr = 32'h3000_0020; m_gnt = 1'b1;   // g+18
      @(negedge clk);
      check("drain_gnt", 32'(s_gnt), 32'd0);
      check("drain_mreq", 32'(m_req), 32'd0);
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      check("irq_set", 32'(timeout_irq), 32'd1);
      check("tcnt_one", 32'(timeout_cnt), 32'd1);
`endif
      for (int k = 19; k <= 21; k++) begin
         step();
         @(negedge clk);
         check("drain_gnt_hold", 32'(s_gnt), 32'd0);
      end
      step(); m_rvalid = 1'b1; m_rdata = 32'hBAD0_0BAD;                // g+22
      @(negedge clk);
      check("late_gnt", 32'(s_gnt), 32'd0);
      check("late_not_fwd", 32'(s_rvalid), 32'd0);
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;                         // g+23
      @(negedge clk);
      check("regrant_gnt", 32'(s_gnt), 32'd1);
      sb.push_back('{32'hCAFE_0001, 1'b0, cyc + 1});
      step(); s_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;

      // Race: real response in cycle 16 after the grant (cnt = 15).
      step(); s_req = 1'b1; s_we = 1'b0; s_addr = 32'h2000_0040; m_gnt = 1'b1;
      g = cyc; sb.push_back('{32'hA5A5_0016, 1'b0, g + 16});
      step(); s_req = 1'b0; m_gnt = 1'b0;
      repeat (14) step();               // g+15
      step(); m_rvalid = 1'b1; m_rdata = 32'hA5A5_0016;                 // g+16
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;                         // g+17
      step();
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      @(negedge clk);
      check("race_tcnt", 32'(timeout_cnt), 32'd1);
`endif

      // Back-to-back: request held high, second grant only after rvalid.
      step(); s_req = 1'b1; s_addr = 32'h4000_0000; m_gnt = 1'b1;
      g = cyc; sb.push_back('{32'h1111_0001, 1'b0, g + 2});
      @(negedge clk);
      check("b2b_gnt0", 32'(s_gnt), 32'd1);
      step(); s_addr = 32'h4000_0004;
      @(negedge clk);
      check("b2b_gnt1", 32'(s_gnt), 32'd0);
      check("b2b_mreq1", 32'(m_req), 32'd0);
      step(); m_rvalid = 1'b1; m_rdata = 32'h1111_0001;
      @(negedge clk);
      check("b2b_gnt2", 32'(s_gnt), 32'd0);
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      check("b2b_gnt3", 32'(s_gnt), 32'd1);
      check("b2b_addr3", m_addr, 32'h4000_0004);
      sb.push_back('{32'h2222_0002, 1'b0, cyc + 1});
      step(); s_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2222_0002;
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;

      // Reset in WAIT_R: the response is lost and the outputs clear immediately.
      step(); s_req = 1'b1; s_addr = 32'h5000_0000; m_gnt = 1'b1;
      step(); s_req = 1'b0; m_gnt = 1'b0;
      step(); s_addr = 32'h0; rst_ni = 1'b0;
      #1;
      check("rst_gnt", 32'(s_gnt), 32'd0);
      check("rst_rvalid", 32'(s_rvalid), 32'd0);
      check("rst_mreq", 32'(m_req), 32'd0);
      check("rst_rdata", s_rdata, 32'h0);
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      check("rst_irq", 32'(timeout_irq), 32'd0);
      check("rst_tcnt", 32'(timeout_cnt), 32'd0);
`endif
      step(); rst_ni = 1'b1;

      // Fresh timeout after reset, then drain to its bound with no response.
      step(); s_req = 1'b1; s_addr = 32'h6000_0000; m_gnt = 1'b1;
      g = cyc; sb.push_back('{32'hDEAD_BEEF, 1'b1, g + 17});
      step(); s_req = 1'b0; m_gnt = 1'b0;
      repeat (16) step();               // g+17
      step(); s_req = 1'b1; m_gnt = 1'b1;                               // g+18
`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      @(negedge clk);
      check("irq_after_rst", 32'(timeout_irq), 32'd1);
      check("tcnt_after_rst", 32'(timeout_cnt), 32'd1);
`endif
      repeat (15) step();               // g+33, last DRAIN cycle
      @(negedge clk);
      check("drain_bound_gnt", 32'(s_gnt), 32'd0);
      step();                           // g+34, back in IDLE
      @(negedge clk);
      check("drain_exit_gnt", 32'(s_gnt), 32'd1);
      sb.push_back('{32'h7777_0007, 1'b0, cyc + 1});
      step(); s_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777_0007;
      step(); m_rvalid = 1'b0; m_rdata = 32'h0;

`ifdef SAP_OBI_TIMEOUT_IRQ_EN
      step(); irq_clr = 1'b1;
      step(); irq_clr = 1'b0;
      @(negedge clk);
      check("irq_clr", 32'(timeout_irq), 32'd0);
      check("tcnt_clr", 32'(timeout_cnt), 32'd0);
`endif

      repeat (3) step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
